// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a power-of-two byte FIFO.
// The frame being shifted is held outside the FIFO, so fifo_count covers only waiting bytes.
module uart_tx_fifo #(
    parameter int div_ratio  = 868,
    parameter int fifo_depth = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          tx_line_o,
    output logic                          busy_o,
    output logic [$clog2(fifo_depth):0]   fifo_count_o,
    output logic                          ovf_o
);
    localparam int AW = $clog2(fifo_depth);
    localparam int BW = $clog2(div_ratio);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem_q [fifo_depth];
    logic          tx_line_q, tx_line_d, ovf_q, ovf_d;
    logic          push, pop, tc, has_data;

    assign tc         = cnt_q == BW'(div_ratio - 1);
    assign has_data   = count_q != '0;
    assign tx_ready_o = count_q != (AW+1)'(fifo_depth);
    assign push       = tx_valid_i && tx_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            tx_line_q <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            wr_q      <= wr_q + AW'(push);
            rd_q      <= rd_q + AW'(pop);
            count_q   <= count_d;
            tx_line_q <= tx_line_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_q] <= tx_data_i;
    end

    // A pop happens from IDLE, or at the end of STOP so frames run back to back.
    always_comb begin
        state_d = state_q;
        cnt_d   = tc ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                pop     = has_data;
                state_d = has_data ? START : IDLE;
            end
            START: if (tc) begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: if (tc) begin
                state_d = idx_q == 3'd7 ? STOP : DATA;
                idx_d   = idx_q + 1'b1;
            end
            STOP: if (tc) begin
                pop     = has_data;
                state_d = has_data ? START : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Line level is derived from the next state so it is registered with no glitch.
    always_comb begin
        count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        data_d    = pop ? mem_q[rd_q] : data_q;
        tx_line_d = state_d == START ? 1'b0 : state_d == DATA ? data_d[idx_d] : 1'b1;
        ovf_d     = tx_valid_i && !tx_ready_o;
    end

    assign tx_line_o    = tx_line_q;
    assign busy_o       = state_q != IDLE;
    assign fifo_count_o = count_q;
    assign ovf_o        = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random checks of uart_tx_fifo (div_ratio=8, fifo_depth=4)
// against a transaction-level FIFO/frame model and an independent mid-bit 8N1 receiver.
module tb_uart_tx_fifo;
    logic       clk, rst, tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready_o, tx_line_o, busy_o, ovf_o;
    logic [2:0] fifo_count_o;

    int vectors = 0, miscompares = 0;
    int cyc = 0, rst_cnt = 0, busy_cnt = 0, ovf_cnt = 0;
    int rx_glitch = 0, rx_stop_err = 0;
    int n0, a0;

    logic [7:0] mq[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rxq[$];
    logic [7:0] cur = 8'h00;
    int         m_start = 0, m_end = 0, m_acc = 0;
    logic       m_ovf = 1'b0;

    uart_tx_fifo #(.div_ratio(8), .fifo_depth(4)) dut (
        .clk(clk),
        .rst(rst),
        .tx_data_i(tx_data),
        .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready_o),
        .tx_line_o(tx_line_o),
        .busy_o(busy_o),
        .fifo_count_o(fifo_count_o),
        .ovf_o(ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, want);
        end
    endtask

    // Line level after edge cyc: frame bit k = start, data LSB first, stop.
    function automatic logic exp_line();
        int k;
        if (cyc >= m_end) return 1'b1;
        k = (cyc - m_start) / 8;
        return k == 0 ? 1'b0 : k == 9 ? 1'b1 : cur[k-1];
    endfunction

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        logic ready, do_pop;
        rst = r; tx_valid = v; tx_data = d;
        if (r) rst_cnt++;
        @(posedge clk);
        cyc++;
        if (r) begin
            if (cyc < m_end) void'(exp_rx.pop_back());
            mq.delete();
            m_end = 0;
            m_ovf = 1'b0;
        end else begin
            ready  = mq.size() != 4;
            do_pop = cyc >= m_end && mq.size() > 0;
            if (do_pop) begin
                cur = mq.pop_front();
                exp_rx.push_back(cur);
                m_start = cyc;
                m_end = cyc + 80;
            end
            if (v && ready) begin
                mq.push_back(d);
                m_acc++;
            end
            m_ovf = v && !ready;
        end
        #1;
        busy_cnt += (busy_o === 1'b1) ? 1 : 0;
        ovf_cnt  += (ovf_o === 1'b1) ? 1 : 0;
        chk("line", tx_line_o, exp_line());
        chk("busy", busy_o, cyc < m_end);
        chk("count", fifo_count_o, mq.size());
        chk("ready", tx_ready_o, mq.size() != 4);
        chk("ovf", ovf_o, m_ovf);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && (cyc < m_end || mq.size() > 0); i++) step(0, 0, 8'h00);
        repeat (4) step(0, 0, 8'h00);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_rx_frames"}, rxq.size(), exp_rx.size());
        for (int i = 0; i < rxq.size() && i < exp_rx.size(); i++)
            chk({tag, "_rx_byte"}, rxq[i], exp_rx[i]);
    endtask

    // Independent receiver: detect start, sample every bit at its middle.
    initial begin
        logic [7:0] b;
        logic       ok;
        int         rc;
        forever begin
            @(posedge clk); #2;
            if (tx_line_o === 1'b0) begin
                rc = rst_cnt;
                repeat (4) @(posedge clk);
                #2;
                ok = tx_line_o === 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(posedge clk);
                    #2;
                    b[i] = tx_line_o;
                end
                repeat (8) @(posedge clk);
                #2;
                if (rst_cnt == rc) begin
                    if (!ok) rx_glitch++;
                    if (tx_line_o !== 1'b1) rx_stop_err++;
                    rxq.push_back(b);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        step(1, 0, 8'h00);
        step(1, 1, 8'h5A);
        chk("rst_line", tx_line_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_count", fifo_count_o, 0);
        chk("rst_ready", tx_ready_o, 1);
        chk("rst_ovf", ovf_o, 0);
        repeat (20) step(0, 0, 8'h00);
        chk("idle_line", tx_line_o, 1);

        busy_cnt = 0;
        step(0, 1, 8'h55);
        chk("t1_e0_line", tx_line_o, 1);
        step(0, 0, 8'h00);
        chk("t1_fall", tx_line_o, 0);
        drain();
        chk("t1_busy_cycles", busy_cnt, 80);
        check_rx("t1");

        busy_cnt = 0;
        step(0, 1, 8'hA3);
        step(0, 1, 8'h0F);
        drain();
        chk("t2_busy_cycles", busy_cnt, 160);
        chk("t2_last", rxq[rxq.size()-1], 8'h0F);
        chk("t2_first", rxq[rxq.size()-2], 8'hA3);
        check_rx("t2");

        ovf_cnt = 0;
        n0 = rxq.size();
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 8'($urandom));
            if (i == 4) chk("t3_ready_full", tx_ready_o, 0);
            if (i == 5) chk("t3_ovf", ovf_o, 1);
        end
        step(0, 0, 8'h00);
        chk("t3_ovf_once", ovf_o, 0);
        drain();
        chk("t3_ovf_pulses", ovf_cnt, 1);
        chk("t3_frames", rxq.size() - n0, 5);
        check_rx("t3");

        n0 = rxq.size();
        step(0, 1, 8'hC6);
        step(0, 1, 8'h39);
        for (int i = 0; i < 200 && cyc + 1 < m_end; i++) step(0, 0, 8'h00);
        chk("t4_count_before", fifo_count_o, 1);
        step(0, 1, 8'h7E);
        chk("t4_count_after", fifo_count_o, 1);
        chk("t4_restart", tx_line_o, 0);
        drain();
        chk("t4_frames", rxq.size() - n0, 3);
        chk("t4_last", rxq[rxq.size()-1], 8'h7E);
        check_rx("t4");

        step(0, 1, 8'hEF);
        step(0, 1, 8'h22);
        step(0, 1, 8'h33);
        for (int i = 0; i < 200 && cyc - m_start < 44; i++) step(0, 0, 8'h00);
        chk("t5_bit4_low", tx_line_o, 0);
        n0 = rxq.size();
        step(1, 0, 8'h00);
        chk("t5_line", tx_line_o, 1);
        chk("t5_count", fifo_count_o, 0);
        chk("t5_busy", busy_o, 0);
        step(1, 1, 8'hFF);
        chk("t5_rst_write", fifo_count_o, 0);
        repeat (200) step(0, 0, 8'h00);
        chk("t5_no_frames", rxq.size() - n0, 0);
        chk("t5_idle_line", tx_line_o, 1);
        check_rx("t5");

        a0 = m_acc;
        for (int i = 0; i < 60000 && m_acc - a0 < 256; i++)
            step(0, $urandom_range(0, 99) < ((m_acc - a0) < 128 ? 60 : 2), 8'($urandom));
        drain();
        check_rx("t6");
        chk("rx_glitch", rx_glitch, 0);
        chk("rx_stop_err", rx_stop_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
